// File: rtl/hw_priority_decoder.sv
// Registered binary-to-one-hot decoder with a valid/ready handshake.
// Each accepted index is driven for HOLD cycles, followed by a one-cycle all-zero gap with a done pulse.
module hw_priority_decoder #(
  parameter int n    = 3,
  parameter int HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [n-1:0]      dec_in,
  output logic              dec_ready,
  output logic [2**n-1:0]   dec_op,
  output logic              dec_done
);

  localparam int W  = 2**n;
  localparam int CW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   next_cnt;
  logic [n-1:0]    idx;
  logic [n-1:0]    next_idx;
  logic [W-1:0]    next_op;
  logic            next_done;

  function automatic logic [W-1:0] onehot(input logic [n-1:0] i);
    logic [W-1:0] v;
    v    = {W{1'b0}};
    v[i] = 1'b1;
    return v;
  endfunction

  // Next-state, hold counter and next registered outputs.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_idx   = idx;
    case (state)
      IDLE: begin
        if (dec_valid) begin
          next_state = DRIVE;
          next_cnt   = CW'(HOLD - 1);
          next_idx   = dec_in;
        end else begin
          next_state = IDLE;
        end
      end
      DRIVE: begin
        if (cnt == {CW{1'b0}}) begin
          next_state = GAP;
        end else begin
          next_cnt = cnt - CW'(1);
        end
      end
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    if (next_state == DRIVE) begin
      next_op = onehot(next_idx);
    end else begin
      next_op = {W{1'b0}};
    end
    next_done = (next_state == GAP);
  end

  // State, counter, latched index and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= {CW{1'b0}};
      idx      <= {n{1'b0}};
      dec_op   <= {W{1'b0}};
      dec_done <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      idx      <= next_idx;
      dec_op   <= next_op;
      dec_done <= next_done;
    end
  end

  assign dec_ready = (state == IDLE);

endmodule

// File: tb/tb_hw_priority_decoder.sv
// Scoreboard bench: two decoders (HOLD=4 and HOLD=1) share random and directed stimulus;
// a timing model pushes expected per-cycle outputs, a monitor pops and compares them.
module tb_hw_priority_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid;
  logic [2:0] dec_in;
  logic [7:0] op4, op1;
  logic       done4, done1, ready4, ready1;

  always #10 clk = ~clk;

  hw_priority_decoder #(.n(3), .HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_in(dec_in),
    .dec_ready(ready4), .dec_op(op4), .dec_done(done4)
  );

  hw_priority_decoder #(.n(3), .HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_in(dec_in),
    .dec_ready(ready1), .dec_op(op1), .dec_done(done1)
  );

  typedef struct packed {
    logic [7:0] op;
    logic       done;
    logic       ready;
  } exp_t;

  int   checks = 0;
  int   fails  = 0;
  exp_t q4[$];
  exp_t q1[$];
  // age = edges since the last accept; anything beyond hold means idle
  int   age[2]  = '{5, 2};
  int   midx[2] = '{0, 0};
  int   hold[2] = '{4, 1};
  bit   acc4;

  function automatic exp_t model_edge(input int k, input logic r, input logic v, input logic [2:0] d);
    exp_t e;
    bit   rdy;
    bit   acc;
    rdy = (age[k] > hold[k]);
    acc = 1'b0;
    if (r) begin
      age[k]  = hold[k] + 1;
      midx[k] = 0;
    end else if (rdy && v) begin
      age[k]  = 0;
      midx[k] = int'(d);
      acc     = 1'b1;
    end else if (age[k] <= hold[k]) begin
      age[k] = age[k] + 1;
    end
    e.op    = (age[k] < hold[k]) ? 8'(1 << midx[k]) : 8'h00;
    e.done  = (age[k] == hold[k]);
    e.ready = (age[k] > hold[k]);
    if (k == 0) acc4 = acc;
    return e;
  endfunction

  task automatic step(input logic r, input logic v, input logic [2:0] d);
    rst       = r;
    dec_valid = v;
    dec_in    = d;
    @(posedge clk);
    q4.push_back(model_edge(0, r, v, d));
    q1.push_back(model_edge(1, r, v, d));
    #1;
  endtask

  task automatic cmp(input string name, input logic [7:0] op, input logic done,
                     input logic ready, input exp_t e);
    checks += 4;
    if (op !== e.op) begin
      fails++;
      $display("FAIL %s dec_op: got %b expected %b at %0t", name, op, e.op, $time);
    end
    if (done !== e.done) begin
      fails++;
      $display("FAIL %s dec_done: got %b expected %b at %0t", name, done, e.done, $time);
    end
    if (ready !== e.ready) begin
      fails++;
      $display("FAIL %s dec_ready: got %b expected %b at %0t", name, ready, e.ready, $time);
    end
    if ($countones(op) > 1) begin
      fails++;
      $display("FAIL %s onehot: got %b expected at most one bit at %0t", name, op, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      cmp("hold4", op4, done4, ready4, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp("hold1", op1, done1, ready1, e);
    end
  end

  initial begin
    int guard;
    rst = 1'b1; dec_valid = 1'b1; dec_in = 3'd5;
    // reset with a pending request: nothing may be accepted
    step(1'b1, 1'b1, 3'd5);
    step(1'b1, 1'b1, 3'd5);
    step(1'b0, 1'b0, 3'd0);

    // single decode of index 7
    step(1'b0, 1'b1, 3'd7);
    repeat (8) step(1'b0, 1'b0, 3'd0);

    // full sweep, each index held until the model shows it accepted
    for (int i = 0; i < 8; i++) begin
      guard = 0;
      do begin
        step(1'b0, 1'b1, 3'(i));
        guard++;
      end while (!acc4 && guard < 20);
      checks++;
      if (!acc4) begin
        fails++;
        $display("FAIL sweep_accept: index %0d not accepted within %0d cycles", i, guard);
      end
    end
    repeat (8) step(1'b0, 1'b0, 3'd0);

    // back-to-back with dec_in switching during DRIVE
    repeat (2) step(1'b0, 1'b1, 3'd3);
    repeat (12) step(1'b0, 1'b1, 3'd6);
    repeat (8) step(1'b0, 1'b0, 3'd0);

    // reset on the second DRIVE cycle
    step(1'b0, 1'b1, 3'd2);
    step(1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 3'd0);
    repeat (6) step(1'b0, 1'b0, 3'd0);

    // random traffic with occasional resets
    repeat (400) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)));
    end
    repeat (3) step(1'b0, 1'b0, 3'd0);

    @(negedge clk);
    #1;
    checks++;
    if (q4.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending entries expected 0/0", q4.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
